toy_itcm_arb: RTL and testbench

//  Credit-based round-robin arbiter sharing the single ITCM fetch port among N_REQ requesters
//  (default: port 0 = icache MSHR refill, port 1 = prefetcher). The ITCM port is always ready
//  and cannot absorb ack backpressure, so this block limits in-flight reads to MAX_OUTST.
//  It buffers every ack internally and returns it to the requester that issued the read, in issue order.

---
 rtl/toy_itcm_arb_pkg.sv | 17 +
 rtl/toy_itcm_arb_fifo.sv | 48 ++++
 rtl/toy_itcm_arb.sv | 158 +++++++++++++++
 tb/tb_toy_itcm_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_itcm_arb_pkg.sv
// Shared widths and types for the ITCM fetch-port arbiter.
package toy_itcm_arb_pkg;

    localparam int ADDR_WIDTH          = 32;
    localparam int FETCH_DATA_WIDTH    = 64;
    // 1 valid/kind bit + opcode + MSHR index + ROB id
    localparam int ITCM_ENTRY_ID_WIDTH = 8;
    localparam int ITCM_ARB_N_REQ      = 2;
    localparam int ITCM_ARB_MAX_OUTST  = 4;

    // One buffered ITCM ack beat: id sits above data when packed.
    typedef struct packed {
        logic [ITCM_ENTRY_ID_WIDTH-1:0] id;
        logic [FETCH_DATA_WIDTH-1:0]    data;
    } itcm_ack_pld_t;

endpackage

// File: rtl/toy_itcm_arb_fifo.sv
// Generic synchronous FIFO with asynchronous active-low reset.
// Pushes while full and pops while empty are ignored; rdata shows the head.
module toy_itcm_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty can be told apart.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the FIFO to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/toy_itcm_arb.sv
// Credit-based round-robin arbiter for the single ITCM fetch port.
// Reads in flight are capped at MAX_OUTST so every ack fits in the resp
// FIFO; acks are steered back to their issuer in issue order.
module toy_itcm_arb
    import toy_itcm_arb_pkg::*;
#(
    parameter int N_REQ     = ITCM_ARB_N_REQ,
    parameter int MAX_OUTST = ITCM_ARB_MAX_OUTST,
    parameter int ADDR_W    = ADDR_WIDTH,
    parameter int DATA_W    = FETCH_DATA_WIDTH,
    parameter int ID_W      = ITCM_ENTRY_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_vld,
    output logic [N_REQ-1:0]        req_rdy,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*ID_W-1:0]   req_entry_id,
    output logic [N_REQ-1:0]        ack_vld,
    input  logic [N_REQ-1:0]        ack_rdy,
    output logic [DATA_W-1:0]       ack_data,
    output logic [ID_W-1:0]         ack_entry_id,
    output logic                    mem_req_vld,
    input  logic                    mem_req_rdy,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [ID_W-1:0]         mem_req_entry_id,
    input  logic                    mem_ack_vld,
    output logic                    mem_ack_rdy,
    input  logic [DATA_W-1:0]       mem_ack_data,
    input  logic [ID_W-1:0]         mem_ack_entry_id
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both 1. Valid never waits on ready; while valid is high and
    // ready is low, the payload is held stable. The ITCM ack side has no
    // backpressure (mem_ack_rdy is constant 1), so every mem_ack_vld cycle
    // is one beat.

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PLD_W = DATA_W + ID_W;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             any_vld;
    logic             below_max;
    logic             can_issue;
    logic             issue;
    logic             deliver;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0] order_head;
    logic             order_full;
    logic             order_empty;
    logic [PLD_W-1:0] resp_head;
    logic             resp_full;
    logic             resp_empty;

    assign below_max   = (cnt < CNT_W'(MAX_OUTST));
    assign can_issue   = below_max && mem_req_rdy;
    assign mem_req_vld = any_vld && below_max;
    assign issue       = mem_req_vld && mem_req_rdy;
    assign mem_ack_rdy = 1'b1;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        winner  = '0;
        any_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_vld && req_vld[(int'(rr_ptr) + k) % N_REQ]) begin
                winner  = IDX_W'((int'(rr_ptr) + k) % N_REQ);
                any_vld = 1'b1;
            end
        end
    end

    assign mem_req_addr     = req_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign mem_req_entry_id = req_entry_id[int'(winner)*ID_W +: ID_W];

    // Grant only the winner, and only when a credit and the ITCM are free.
    always_comb begin
        req_rdy = '0;
        if (any_vld && can_issue) req_rdy[winner] = 1'b1;
    end

    // Steer the resp FIFO head to the requester recorded at the order FIFO head.
    always_comb begin
        ack_vld = '0;
        if (!resp_empty) ack_vld[order_head] = 1'b1;
    end

    assign deliver      = !resp_empty && ack_rdy[order_head];
    assign ack_entry_id = resp_head[PLD_W-1 -: ID_W];
    assign ack_data     = resp_head[DATA_W-1:0];

    // Pointer moves past the winner only on an actual issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
        end
    end

    // Credit counter: reads issued but not yet delivered to a requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({issue, deliver})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    toy_itcm_arb_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTST)
    ) u_order_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (issue),
        .wdata (winner),
        .pop   (deliver),
        .rdata (order_head),
        .full  (order_full),
        .empty (order_empty)
    );

    toy_itcm_arb_fifo #(
        .WIDTH (PLD_W),
        .DEPTH (MAX_OUTST)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mem_ack_vld),
        .wdata ({mem_ack_entry_id, mem_ack_data}),
        .pop   (deliver),
        .rdata (resp_head),
        .full  (resp_full),
        .empty (resp_empty)
    );

    // The ITCM cannot be stalled, so a beat into a full resp FIFO is lost data.
    a_resp_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_ack_vld && resp_full));
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= CNT_W'(MAX_OUTST));
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(deliver && !issue && cnt == '0));
    a_order_empty_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        order_empty |-> (cnt == '0));
    a_order_not_full_on_issue: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue && order_full));

endmodule

// File: tb/tb_toy_itcm_arb.sv
// Directed bench for toy_itcm_arb paired with a two-stage ITCM stand-in.
module tb_toy_itcm_arb;
    import toy_itcm_arb_pkg::*;

    localparam int N_REQ     = 2;
    localparam int MAX_OUTST = 4;
    localparam int ADDR_W    = ADDR_WIDTH;
    localparam int DATA_W    = FETCH_DATA_WIDTH;
    localparam int ID_W      = ITCM_ENTRY_ID_WIDTH;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]        req_vld;
    logic [N_REQ-1:0]        req_rdy;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*ID_W-1:0]   req_entry_id;
    logic [N_REQ-1:0]        ack_vld;
    logic [N_REQ-1:0]        ack_rdy;
    logic [DATA_W-1:0]       ack_data;
    logic [ID_W-1:0]         ack_entry_id;
    logic                    mem_req_vld;
    logic                    mem_req_rdy;
    logic [ADDR_W-1:0]       mem_req_addr;
    logic [ID_W-1:0]         mem_req_entry_id;
    logic                    mem_ack_vld;
    logic                    mem_ack_rdy;
    logic [DATA_W-1:0]       mem_ack_data;
    logic [ID_W-1:0]         mem_ack_entry_id;

    int n_vec;
    int n_err;
    logic [ID_W:0] exp_q[$];  // {port, entry_id} in expected delivery order

    toy_itcm_arb dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_vld          (req_vld),
        .req_rdy          (req_rdy),
        .req_addr         (req_addr),
        .req_entry_id     (req_entry_id),
        .ack_vld          (ack_vld),
        .ack_rdy          (ack_rdy),
        .ack_data         (ack_data),
        .ack_entry_id     (ack_entry_id),
        .mem_req_vld      (mem_req_vld),
        .mem_req_rdy      (mem_req_rdy),
        .mem_req_addr     (mem_req_addr),
        .mem_req_entry_id (mem_req_entry_id),
        .mem_ack_vld      (mem_ack_vld),
        .mem_ack_rdy      (mem_ack_rdy),
        .mem_ack_data     (mem_ack_data),
        .mem_ack_entry_id (mem_ack_entry_id)
    );

    // ---------------- ITCM stand-in: one delay stage + output register ----------------
    logic             s1_vld;
    logic [ADDR_W-1:0] s1_addr;
    logic [ID_W-1:0]  s1_id;
    logic             o_vld;
    itcm_ack_pld_t    o_pld;

    assign mem_req_rdy      = 1'b1;
    assign mem_ack_vld      = o_vld;
    assign mem_ack_data     = o_pld.data;
    assign mem_ack_entry_id = o_pld.id;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            s1_id   <= '0;
            o_vld   <= 1'b0;
            o_pld   <= '0;
        end else begin
            s1_vld     <= mem_req_vld && mem_req_rdy;
            s1_addr    <= mem_req_addr;
            s1_id      <= mem_req_entry_id;
            o_vld      <= s1_vld;
            o_pld.id   <= s1_id;
            o_pld.data <= {~s1_addr, s1_addr};
        end
    end

    // ITCM read data for a given address (the stand-in returns {~addr, addr}).
    function automatic logic [DATA_W-1:0] itcm_data(input int addr);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(addr);
        return {~a, a};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input int addr, input int id);
        req_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        req_entry_id[port*ID_W +: ID_W] = ID_W'(id);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ack_vld !== 2'b00) begin n_err++; $display("FAIL reset_ack_vld: got %b want 00", ack_vld); end
        n_vec++; if (req_rdy !== 2'b00) begin n_err++; $display("FAIL reset_req_rdy: got %b want 00", req_rdy); end
        n_vec++; if (mem_req_vld !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_vld: got %b want 0", mem_req_vld); end
        n_vec++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt); end
        n_vec++; if (mem_ack_rdy !== 1'b1) begin n_err++; $display("FAIL mem_ack_rdy: got %b want 1", mem_ack_rdy); end
        rst_n = 1'b1;
        tick();
        n_vec++; if (ack_vld !== 2'b00) begin n_err++; $display("FAIL post_reset_ack_vld: got %b want 00", ack_vld); end
    endtask

    task automatic test_single();
        ack_rdy = 2'b11;
        req_vld = 2'b01;
        set_req(0, 'h100, 'h15);
        #1;
        n_vec++; if (mem_req_vld !== 1'b1) begin n_err++; $display("FAIL single_mem_req_vld: got %b want 1", mem_req_vld); end
        n_vec++; if (req_rdy !== 2'b01) begin n_err++; $display("FAIL single_req_rdy: got %b want 01", req_rdy); end
        n_vec++; if (mem_req_addr !== 32'h100) begin n_err++; $display("FAIL single_mem_addr: got %h want 100", mem_req_addr); end
        n_vec++; if (mem_req_entry_id !== 8'h15) begin n_err++; $display("FAIL single_mem_id: got %h want 15", mem_req_entry_id); end
        tick();
        req_vld = 2'b00;
        n_vec++; if (ack_vld !== 2'b00) begin n_err++; $display("FAIL single_ack_early1: got %b want 00", ack_vld); end
        tick();
        n_vec++; if (ack_vld !== 2'b00) begin n_err++; $display("FAIL single_ack_early2: got %b want 00", ack_vld); end
        tick();
        n_vec++; if (ack_vld !== 2'b01) begin n_err++; $display("FAIL single_ack_vld: got %b want 01", ack_vld); end
        n_vec++; if (ack_entry_id !== 8'h15) begin n_err++; $display("FAIL single_ack_id: got %h want 15", ack_entry_id); end
        n_vec++; if (ack_data !== itcm_data('h100)) begin n_err++; $display("FAIL single_ack_data: got %h want %h", ack_data, itcm_data('h100)); end
        tick();
        n_vec++; if (ack_vld !== 2'b00) begin n_err++; $display("FAIL single_ack_done: got %b want 00", ack_vld); end
        n_vec++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL single_cnt: got %0d want 0", dut.cnt); end
    endtask

    task automatic test_fairness();
        int n0;
        int n1;
        logic [ID_W:0] got;
        logic [ID_W:0] want;
        logic [1:0] want_rdy;
        n0 = 0;
        n1 = 0;
        exp_q.delete();
        // fresh pointer so the first grant goes to port 0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        ack_rdy = 2'b11;
        for (int k = 0; k < 20; k++) begin
            if (k < 8) begin
                req_vld = 2'b11;
                set_req(0, 'h1000 + k*8, 'h40 + k);
                set_req(1, 'h2000 + k*8, 'h80 + k);
            end else begin
                req_vld = 2'b00;
            end
            #1;
            if (k < 8) begin
                want_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
                n_vec++; if (req_rdy !== want_rdy) begin n_err++; $display("FAIL fair_grant[%0d]: got %b want %b", k, req_rdy, want_rdy); end
                if (k % 2 == 0) exp_q.push_back({1'b0, 8'(8'h40 + k)});
                else            exp_q.push_back({1'b1, 8'(8'h80 + k)});
            end
            if (ack_vld !== 2'b00) begin
                got = {ack_vld[1], ack_entry_id};
                if (ack_vld[1]) n1++; else n0++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL fair_unexpected_ack: got %h want none", got);
                end else begin
                    want = exp_q.pop_front();
                    n_vec++; if (got !== want) begin n_err++; $display("FAIL fair_ack_order: got %h want %h", got, want); end
                end
            end
            @(posedge clk);
            #1;
        end
        n_vec++; if (n0 != 4) begin n_err++; $display("FAIL fair_acks_port0: got %0d want 4", n0); end
        n_vec++; if (n1 != 4) begin n_err++; $display("FAIL fair_acks_port1: got %0d want 4", n1); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fair_missing_acks: got %0d left want 0", exp_q.size()); end
        n_vec++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL fair_cnt: got %0d want 0", dut.cnt); end
    endtask

    task automatic drain_port0(input string name, input int first_id, input int last_id, input int base_addr);
        int nxt;
        nxt = first_id;
        ack_rdy = 2'b01;
        for (int k = 0; k < 16; k++) begin
            if (ack_vld[0] === 1'b1) begin
                n_vec++; if (ack_entry_id !== ID_W'(nxt)) begin n_err++; $display("FAIL %s_drain_id: got %h want %h", name, ack_entry_id, nxt); end
                n_vec++; if (ack_data !== itcm_data(base_addr + (nxt - first_id)*4)) begin n_err++; $display("FAIL %s_drain_data: got %h want %h", name, ack_data, itcm_data(base_addr + (nxt - first_id)*4)); end
                nxt++;
            end
            tick();
        end
        n_vec++; if (nxt != last_id + 1) begin n_err++; $display("FAIL %s_drain_count: got %0d want %0d", name, nxt - first_id, last_id + 1 - first_id); end
        n_vec++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL %s_drain_cnt: got %0d want 0", name, dut.cnt); end
    endtask

    task automatic test_credit_full();
        int issued;
        issued = 0;
        ack_rdy = 2'b00;
        for (int k = 0; k < 6; k++) begin
            req_vld = 2'b01;
            set_req(0, 'h3000 + issued*4, 'h30 + issued);
            #1;
            n_vec++; if (req_rdy !== ((k < 4) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL full_req_rdy[%0d]: got %b want %b", k, req_rdy, (k < 4) ? 2'b01 : 2'b00); end
            n_vec++; if (mem_req_vld !== (k < 4)) begin n_err++; $display("FAIL full_mem_vld[%0d]: got %b want %b", k, mem_req_vld, k < 4); end
            if (req_rdy[0] === 1'b1) issued++;
            tick();
        end
        n_vec++; if (issued != 4) begin n_err++; $display("FAIL full_issued: got %0d want 4", issued); end
        n_vec++; if (dut.cnt !== 3'd4) begin n_err++; $display("FAIL full_cnt: got %0d want 4", dut.cnt); end
        n_vec++; if (ack_vld !== 2'b01) begin n_err++; $display("FAIL full_ack_vld: got %b want 01", ack_vld); end
        n_vec++; if (ack_entry_id !== 8'h30) begin n_err++; $display("FAIL full_head_id: got %h want 30", ack_entry_id); end
        // one delivery; the freed credit must not be used in the same cycle
        ack_rdy = 2'b01;
        #1;
        n_vec++; if (req_rdy !== 2'b00) begin n_err++; $display("FAIL full_same_cycle_rdy: got %b want 00", req_rdy); end
        n_vec++; if (mem_req_vld !== 1'b0) begin n_err++; $display("FAIL full_same_cycle_mem: got %b want 0", mem_req_vld); end
        tick();
        ack_rdy = 2'b00;
        #1;
        n_vec++; if (req_rdy !== 2'b01) begin n_err++; $display("FAIL full_next_cycle_rdy: got %b want 01", req_rdy); end
        n_vec++; if (dut.cnt !== 3'd3) begin n_err++; $display("FAIL full_after_deliver_cnt: got %0d want 3", dut.cnt); end
        n_vec++; if (ack_entry_id !== 8'h31) begin n_err++; $display("FAIL full_next_head: got %h want 31", ack_entry_id); end
        tick();
        req_vld = 2'b00;
        #1;
        n_vec++; if (dut.cnt !== 3'd4) begin n_err++; $display("FAIL full_refill_cnt: got %0d want 4", dut.cnt); end
        drain_port0("full", 'h31, 'h34, 'h3004);
    endtask

    task automatic test_backpressure();
        int wcnt;
        ack_rdy = 2'b01;
        req_vld = 2'b10;
        set_req(1, 'h300, 'h51);
        #1;
        n_vec++; if (req_rdy !== 2'b10) begin n_err++; $display("FAIL bp_grant1: got %b want 10", req_rdy); end
        tick();
        req_vld = 2'b01;
        set_req(0, 'h304, 'h52);
        #1;
        n_vec++; if (req_rdy !== 2'b01) begin n_err++; $display("FAIL bp_grant0: got %b want 01", req_rdy); end
        tick();
        req_vld = 2'b00;
        wcnt = 0;
        while (ack_vld === 2'b00 && wcnt < 10) begin
            tick();
            wcnt++;
        end
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (ack_vld !== 2'b10) begin n_err++; $display("FAIL bp_hold_vld[%0d]: got %b want 10", k, ack_vld); end
            n_vec++; if (ack_entry_id !== 8'h51) begin n_err++; $display("FAIL bp_hold_id[%0d]: got %h want 51", k, ack_entry_id); end
            n_vec++; if (ack_data !== itcm_data('h300)) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want %h", k, ack_data, itcm_data('h300)); end
            tick();
        end
        ack_rdy = 2'b11;
        tick();
        n_vec++; if (ack_vld !== 2'b01) begin n_err++; $display("FAIL bp_second_vld: got %b want 01", ack_vld); end
        n_vec++; if (ack_entry_id !== 8'h52) begin n_err++; $display("FAIL bp_second_id: got %h want 52", ack_entry_id); end
        tick();
        n_vec++; if (ack_vld !== 2'b00) begin n_err++; $display("FAIL bp_done_vld: got %b want 00", ack_vld); end
        n_vec++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL bp_cnt: got %0d want 0", dut.cnt); end
    endtask

    task automatic test_simultaneous();
        ack_rdy = 2'b00;
        req_vld = 2'b01;
        set_req(0, 'h400, 'h61);
        tick();
        set_req(0, 'h404, 'h62);
        tick();
        req_vld = 2'b00;
        repeat (3) tick();
        n_vec++; if (dut.cnt !== 3'd2) begin n_err++; $display("FAIL sim_cnt_before: got %0d want 2", dut.cnt); end
        n_vec++; if (ack_entry_id !== 8'h61) begin n_err++; $display("FAIL sim_head_before: got %h want 61", ack_entry_id); end
        // issue and delivery on the same edge
        req_vld = 2'b01;
        set_req(0, 'h408, 'h63);
        ack_rdy = 2'b01;
        #1;
        n_vec++; if (req_rdy !== 2'b01) begin n_err++; $display("FAIL sim_req_rdy: got %b want 01", req_rdy); end
        tick();
        req_vld = 2'b00;
        ack_rdy = 2'b00;
        #1;
        n_vec++; if (dut.cnt !== 3'd2) begin n_err++; $display("FAIL sim_cnt_after: got %0d want 2", dut.cnt); end
        n_vec++; if (ack_vld !== 2'b01) begin n_err++; $display("FAIL sim_ack_vld: got %b want 01", ack_vld); end
        n_vec++; if (ack_entry_id !== 8'h62) begin n_err++; $display("FAIL sim_head_after: got %h want 62", ack_entry_id); end
        drain_port0("sim", 'h62, 'h63, 'h404);
    endtask

    task automatic test_reset_mid();
        ack_rdy = 2'b00;
        req_vld = 2'b01;
        set_req(0, 'h500, 'h71);
        tick();
        req_vld = 2'b10;
        set_req(1, 'h504, 'h72);
        tick();
        req_vld = 2'b01;
        set_req(0, 'h508, 'h73);
        tick();
        req_vld = 2'b00;
        rst_n = 1'b0;
        #1;
        n_vec++; if (ack_vld !== 2'b00) begin n_err++; $display("FAIL rmid_ack_vld: got %b want 00", ack_vld); end
        n_vec++; if (req_rdy !== 2'b00) begin n_err++; $display("FAIL rmid_req_rdy: got %b want 00", req_rdy); end
        n_vec++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", dut.cnt); end
        tick();
        n_vec++; if (ack_vld !== 2'b00) begin n_err++; $display("FAIL rmid_ack_vld_held: got %b want 00", ack_vld); end
        rst_n = 1'b1;
        repeat (3) tick();
        n_vec++; if (ack_vld !== 2'b00) begin n_err++; $display("FAIL rmid_no_stale_ack: got %b want 00", ack_vld); end
        ack_rdy = 2'b11;
        req_vld = 2'b01;
        set_req(0, 'h200, 'h7a);
        #1;
        n_vec++; if (req_rdy !== 2'b01) begin n_err++; $display("FAIL rmid_fresh_rdy: got %b want 01", req_rdy); end
        n_vec++; if (mem_req_addr !== 32'h200) begin n_err++; $display("FAIL rmid_fresh_addr: got %h want 200", mem_req_addr); end
        tick();
        req_vld = 2'b00;
        tick();
        tick();
        n_vec++; if (ack_vld !== 2'b01) begin n_err++; $display("FAIL rmid_fresh_ack_vld: got %b want 01", ack_vld); end
        n_vec++; if (ack_entry_id !== 8'h7a) begin n_err++; $display("FAIL rmid_fresh_id: got %h want 7a", ack_entry_id); end
        n_vec++; if (ack_data !== itcm_data('h200)) begin n_err++; $display("FAIL rmid_fresh_data: got %h want %h", ack_data, itcm_data('h200)); end
        tick();
        n_vec++; if (dut.cnt !== 3'd0) begin n_err++; $display("FAIL rmid_fresh_cnt: got %0d want 0", dut.cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        req_vld      = '0;
        req_addr     = '0;
        req_entry_id = '0;
        ack_rdy      = '0;
        test_reset();
        test_single();
        test_fairness();
        test_credit_full();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
